// File: rtl/dht11_frame_reader.sv
// DHT11 single-wire read transaction: host start pulse, sensor response, 40 data bits,
// checksum verification and a one-cycle o_Done pulse that loads the five frame bytes.
module dht11_frame_reader #(
  parameter int START_LOW_CYC  = 900000,
  parameter int BIT_THRESH_CYC = 2500,
  parameter int TIMEOUT_CYC    = 5000,
  parameter int CNT_W          = 20
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Start,
  input  logic       i_Dht_Data,
  output logic       o_Dht_Drive_Low,
  output logic [7:0] o_Hum_Int,
  output logic [7:0] o_Hum_Float,
  output logic [7:0] o_Temp_Int,
  output logic [7:0] o_Temp_Float,
  output logic [7:0] o_Crc,
  output logic       o_Done,
  output logic       o_Busy,
  output logic       o_Err,
  output logic [1:0] o_Err_Code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_LOW,
    S_WAIT_RESP,
    S_RESP_LOW,
    S_RESP_HIGH,
    S_BIT_LOW,
    S_BIT_HIGH,
    S_CHECK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             sync1_q, sync2_q, prev_q;
  logic [39:0]      shift_q, shift_d;
  logic [39:0]      out_q, out_d;
  logic [5:0]       bitIdx_q, bitIdx_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [1:0]       errCode_q, errCode_d;

  logic             fall, rise, timeout, abort;
  logic [1:0]       abortCode;
  logic [7:0]       sum;

  // The line idles high (pull-up), so the synchroniser resets to 1 to avoid a false edge.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= i_Dht_Data;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall    = prev_q & ~sync2_q;
  assign rise    = ~prev_q & sync2_q;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC));
  assign sum     = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      out_q     <= '0;
      bitIdx_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      errCode_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
      shift_q   <= shift_d;
      out_q     <= out_d;
      bitIdx_q  <= bitIdx_d;
      done_q    <= done_d;
      err_q     <= err_d;
      errCode_q <= errCode_d;
    end
  end

  // Edges are tested before timeouts so an edge arriving on the timeout cycle still counts.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    out_d     = out_q;
    bitIdx_d  = bitIdx_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    errCode_d = errCode_q;
    abort     = 1'b0;
    abortCode = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          state_d   = S_START_LOW;
          errCode_d = 2'b00;
        end
      end
      S_START_LOW: begin
        if (cnt_q == CNT_W'(START_LOW_CYC - 1)) state_d = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        if (fall) state_d = S_RESP_LOW;
        else if (timeout) begin
          abort     = 1'b1;
          abortCode = 2'b01;
        end
      end
      S_RESP_LOW: begin
        if (rise) state_d = S_RESP_HIGH;
        else if (timeout) begin
          abort     = 1'b1;
          abortCode = 2'b01;
        end
      end
      S_RESP_HIGH: begin
        if (fall) begin
          state_d  = S_BIT_LOW;
          bitIdx_d = '0;
        end else if (timeout) begin
          abort     = 1'b1;
          abortCode = 2'b01;
        end
      end
      S_BIT_LOW: begin
        if (rise) state_d = S_BIT_HIGH;
        else if (timeout) begin
          abort     = 1'b1;
          abortCode = 2'b10;
        end
      end
      S_BIT_HIGH: begin
        if (fall) begin
          shift_d = {shift_q[38:0], (cnt_q > CNT_W'(BIT_THRESH_CYC))};
          if (bitIdx_q == 6'd39) state_d = S_CHECK;
          else begin
            state_d  = S_BIT_LOW;
            bitIdx_d = bitIdx_q + 6'd1;
          end
        end else if (timeout) begin
          abort     = 1'b1;
          abortCode = 2'b10;
        end
      end
      S_CHECK: begin
        if (sum == shift_q[7:0]) begin
          out_d   = shift_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          abort     = 1'b1;
          abortCode = 2'b11;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d   = S_IDLE;
      err_d     = 1'b1;
      errCode_d = abortCode;
    end
  end

  assign o_Dht_Drive_Low = (state_q == S_START_LOW);
  assign o_Busy          = (state_q != S_IDLE);
  assign o_Done          = done_q;
  assign o_Err           = err_q;
  assign o_Err_Code      = errCode_q;
  assign o_Hum_Int       = out_q[39:32];
  assign o_Hum_Float     = out_q[31:24];
  assign o_Temp_Int      = out_q[23:16];
  assign o_Temp_Float    = out_q[15:8];
  assign o_Crc           = out_q[7:0];

endmodule

// File: tb/tb_dht11_frame_reader.sv
// Directed bench for dht11_frame_reader: a cycle-level DHT11 sensor model drives the line
// and the bench compares outputs against hand-computed frames, codes and timings.
module tb_dht11_frame_reader;

  localparam int START_LOW_CYC  = 40;
  localparam int BIT_THRESH_CYC = 20;
  localparam int TIMEOUT_CYC    = 60;
  localparam int CNT_W          = 8;

  logic       clock = 1'b0;
  logic       rstN = 1'b0;
  logic       iStart = 1'b0;
  logic       sensorLine = 1'b1;
  logic       dhtData;
  logic       driveLow;
  logic [7:0] humInt, humFloat, tempInt, tempFloat, crc;
  logic       done, busy, err;
  logic [1:0] errCode;

  int compareCount = 0;
  int failCount = 0;

  int         doneTotal = 0;
  int         errTotal = 0;
  int         driveTotal = 0;
  int         riseTotal = 0;
  logic       prevDrive = 1'b0;
  logic [39:0] capData = '0;
  logic       busyAtDone = 1'b1;

  // Wired line: the host pulling low overrides the sensor / pull-up.
  assign dhtData = sensorLine & ~driveLow;

  always #5 clock = ~clock;

  dht11_frame_reader #(
    .START_LOW_CYC (START_LOW_CYC),
    .BIT_THRESH_CYC(BIT_THRESH_CYC),
    .TIMEOUT_CYC   (TIMEOUT_CYC),
    .CNT_W         (CNT_W)
  ) dut (
    .i_Clk          (clock),
    .i_Rst_n        (rstN),
    .i_Start        (iStart),
    .i_Dht_Data     (dhtData),
    .o_Dht_Drive_Low(driveLow),
    .o_Hum_Int      (humInt),
    .o_Hum_Float    (humFloat),
    .o_Temp_Int     (tempInt),
    .o_Temp_Float   (tempFloat),
    .o_Crc          (crc),
    .o_Done         (done),
    .o_Busy         (busy),
    .o_Err          (err),
    .o_Err_Code     (errCode)
  );

  always @(negedge clock) begin
    prevDrive <= driveLow;
    if (driveLow) driveTotal <= driveTotal + 1;
    if (driveLow && !prevDrive) riseTotal <= riseTotal + 1;
    if (err) errTotal <= errTotal + 1;
    if (done) begin
      doneTotal  <= doneTotal + 1;
      capData    <= {humInt, humFloat, tempInt, tempFloat, crc};
      busyAtDone <= busy;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic startRead();
    @(negedge clock);
    iStart = 1'b1;
    @(negedge clock);
    iStart = 1'b0;
  endtask

  // Sensor model: after the host releases the line, 16 low / 16 high response, then per bit
  // 10 low and 8 ('0') or 30 ('1') high, then a 10-cycle low. With nBits < 40 the line is
  // left high after the trailing low, i.e. stuck in the high phase of bit nBits.
  task automatic applyStimulus(input logic [39:0] frame, input int nBits, input bit extraStart);
    int budget = 0;
    while (driveLow && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    checkOutput("hostReleaseWait", 64'(budget >= 200), 64'd0);
    waitCycles(3);
    sensorLine = 1'b0;
    waitCycles(16);
    sensorLine = 1'b1;
    waitCycles(16);
    for (int i = 0; i < nBits; i++) begin
      sensorLine = 1'b0;
      if (extraStart && i == 5) begin
        iStart = 1'b1;
        @(negedge clock);
        iStart = 1'b0;
        waitCycles(9);
      end else begin
        waitCycles(10);
      end
      sensorLine = 1'b1;
      waitCycles(frame[39-i] ? 30 : 8);
    end
    sensorLine = 1'b0;
    waitCycles(10);
    sensorLine = 1'b1;
  endtask

  int doneBase, errBase, driveBase, riseBase;

  task automatic snapshot();
    doneBase  = doneTotal;
    errBase   = errTotal;
    driveBase = driveTotal;
    riseBase  = riseTotal;
  endtask

  function automatic logic [39:0] outBytes();
    return {humInt, humFloat, tempInt, tempFloat, crc};
  endfunction

  initial begin
    int k;
    // Reset
    rstN = 1'b0;
    waitCycles(2);
    checkOutput("resetData", 64'(outBytes()), 64'd0);
    checkOutput("resetFlags", {58'd0, done, busy, err, errCode, driveLow}, 64'd0);
    rstN = 1'b1;
    waitCycles(5);

    // Good frame
    snapshot();
    startRead();
    applyStimulus(40'h3C_00_19_05_5A, 40, 1'b0);
    waitCycles(20);
    checkOutput("goodDriveCycles", 64'(driveTotal - driveBase), 64'(START_LOW_CYC));
    checkOutput("goodDoneCount", 64'(doneTotal - doneBase), 64'd1);
    checkOutput("goodErrCount", 64'(errTotal - errBase), 64'd0);
    checkOutput("goodCapData", 64'(capData), 64'h3C_00_19_05_5A);
    checkOutput("goodBusyAtDone", 64'(busyAtDone), 64'd0);
    checkOutput("goodErrCode", 64'(errCode), 64'd0);
    checkOutput("goodBusyAfter", 64'(busy), 64'd0);

    // Bad checksum keeps previous data
    snapshot();
    startRead();
    applyStimulus(40'h3C_00_19_05_5B, 40, 1'b0);
    waitCycles(20);
    checkOutput("badErrCount", 64'(errTotal - errBase), 64'd1);
    checkOutput("badDoneCount", 64'(doneTotal - doneBase), 64'd0);
    checkOutput("badErrCode", 64'(errCode), 64'd3);
    checkOutput("badDataHeld", 64'(outBytes()), 64'h3C_00_19_05_5A);

    // Checksum with 8-bit wrap: FF+FF+01+02 = 0x201 -> 01
    snapshot();
    startRead();
    applyStimulus(40'hFF_FF_01_02_01, 40, 1'b0);
    waitCycles(20);
    checkOutput("wrapDoneCount", 64'(doneTotal - doneBase), 64'd1);
    checkOutput("wrapTempInt", 64'(tempInt), 64'h01);
    checkOutput("wrapData", 64'(outBytes()), 64'hFF_FF_01_02_01);
    checkOutput("wrapErrCode", 64'(errCode), 64'd0);

    // No response: start edge + 40 low + 60 timeout, then o_Err registered one edge later
    snapshot();
    @(negedge clock);
    iStart = 1'b1;
    k = 0;
    do begin
      @(negedge clock);
      k++;
      if (k == 1) iStart = 1'b0;
    end while (!err && k < 400);
    checkOutput("noRespLatency", 64'(k - 1), 64'(START_LOW_CYC + TIMEOUT_CYC + 1));
    checkOutput("noRespErrCode", 64'(errCode), 64'd1);
    checkOutput("noRespReleased", {62'd0, driveLow, busy}, 64'd0);
    waitCycles(5);
    checkOutput("noRespErrPulse", 64'(errTotal - errBase), 64'd1);
    checkOutput("noRespCodeHeld", 64'(errCode), 64'd1);

    // Stuck high in bit 12 with a second start request mid-frame
    snapshot();
    startRead();
    applyStimulus(40'hA5_5A_C3_3C_00, 12, 1'b1);
    waitCycles(100);
    checkOutput("stuckErrCount", 64'(errTotal - errBase), 64'd1);
    checkOutput("stuckErrCode", 64'(errCode), 64'd2);
    checkOutput("stuckDoneCount", 64'(doneTotal - doneBase), 64'd0);
    checkOutput("stuckStartOnce", 64'(riseTotal - riseBase), 64'd1);
    checkOutput("stuckDataHeld", 64'(outBytes()), 64'hFF_FF_01_02_01);

    // Reset during the bit stream
    snapshot();
    startRead();
    applyStimulus(40'hA5_5A_C3_3C_00, 20, 1'b0);
    waitCycles(5);
    checkOutput("preResetBusy", 64'(busy), 64'd1);
    rstN = 1'b0;
    @(negedge clock);
    rstN = 1'b1;
    checkOutput("midResetData", 64'(outBytes()), 64'd0);
    checkOutput("midResetFlags", {58'd0, done, busy, err, errCode, driveLow}, 64'd0);
    waitCycles(100);
    checkOutput("midResetNoErr", 64'(errTotal - errBase), 64'd0);
    checkOutput("midResetNoDone", 64'(doneTotal - doneBase), 64'd0);

    // Good frame after reset: 41+02+17+08 = 62
    snapshot();
    startRead();
    applyStimulus(40'h41_02_17_08_62, 40, 1'b0);
    waitCycles(20);
    checkOutput("afterResetDone", 64'(doneTotal - doneBase), 64'd1);
    checkOutput("afterResetData", 64'(outBytes()), 64'h41_02_17_08_62);
    checkOutput("afterResetErr", 64'(errTotal - errBase), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/dht11_frame_reader.md
Name: dht11_frame_reader

Overview:
- Upstream stage of the sensor data-select interface.
- Runs the DHT11 single-wire read transaction: host start pulse, sensor response, 40 data bits.
- Checks the checksum and presents humidity/temperature integer and fraction bytes plus the checksum byte.
- o_Done pulses for one cycle per good frame and drives the downstream interface's enable; the downstream block latches on that edge.

Parameters:
- START_LOW_CYC, 900000: cycles the host holds the line low for the start pulse (18 ms at 50 MHz).
- BIT_THRESH_CYC, 2500: a bit's high phase longer than this many cycles is a 1 (50 us at 50 MHz).
- TIMEOUT_CYC, 5000: maximum cycles spent in any sensor-driven phase before abort (100 us).
- CNT_W, 20: phase-counter width; must hold max(START_LOW_CYC, TIMEOUT_CYC).

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  synchronous active-low reset.
- i_Start  in  1  one-cycle read request.
- i_Dht_Data  in  1  raw sensor line (asynchronous; external pull-up).
- o_Dht_Drive_Low  out  1  1 = tri-state driver pulls the line low, 0 = release.
- o_Hum_Int  out  8  humidity integer byte.
- o_Hum_Float  out  8  humidity fraction byte.
- o_Temp_Int  out  8  temperature integer byte.
- o_Temp_Float  out  8  temperature fraction byte.
- o_Crc  out  8  received checksum byte.
- o_Done  out  1  one-cycle pulse: a good frame has been loaded.
- o_Busy  out  1  high whenever the FSM is not in IDLE.
- o_Err  out  1  one-cycle pulse on abort.
- o_Err_Code  out  2  00 none, 01 no sensor response, 10 bit/phase timeout, 11 checksum mismatch; holds until the next start.

Behaviour:
- Reset (i_Rst_n=0 at the clock edge): all outputs 0, line released, FSM to IDLE, counter and shift register cleared. Reset mid-frame aborts immediately with no o_Done and no o_Err.
- Input synchronisation: i_Dht_Data passes through a 2-flop synchroniser. Edges are detected on the synchronised value (2-3 cycle sensing latency). Reset value of the synchroniser flops is 1.
- Phase counter: clears on every state transition and increments each cycle otherwise.
- IDLE: on i_Start=1, go to START_LOW, set o_Busy, clear o_Err_Code. i_Start is ignored in every other state.
- START_LOW: o_Dht_Drive_Low=1. When the counter reaches START_LOW_CYC-1, release the line and go to WAIT_RESP.
- WAIT_RESP: on a synchronised falling edge, go to RESP_LOW. If the counter reaches TIMEOUT_CYC, abort with code 01.
- RESP_LOW: on a rising edge, go to RESP_HIGH. On timeout, abort with code 01.
- RESP_HIGH: on a falling edge, go to BIT_LOW with the bit index at 0. On timeout, abort with code 01.
- BIT_LOW: on a rising edge, go to BIT_HIGH. On timeout, abort with code 10.
- BIT_HIGH, on a falling edge:
  - Shift in bit = (counter > BIT_THRESH_CYC), MSB first, into a 40-bit register.
  - If this was bit 39, go to CHECK; otherwise go to BIT_LOW.
- BIT_HIGH timeout: abort with code 10.
- Frame order, first received to last: hum_int, hum_float, temp_int, temp_float, crc.
- CHECK (one cycle): sum = (b0+b1+b2+b3) mod 256, 8-bit wrap. If sum == b4, load all five output registers and pulse o_Done the following cycle, with data valid in that same cycle. Otherwise abort with code 11.
- Output data registers change only on a good frame. On any abort they keep their previous values.
- Abort: pulse o_Err for one cycle, set o_Err_Code, release the line, return to IDLE.
- After o_Done, return to IDLE; o_Busy falls in the o_Done cycle.
- o_Dht_Drive_Low is 1 only in START_LOW.
- A falling edge and a timeout in the same cycle: the edge wins.

Test Plan (sim parameters START_LOW_CYC=40, BIT_THRESH_CYC=20, TIMEOUT_CYC=60, CNT_W=8; sensor model: response 16 low/16 high, bit low 10, '0' high 8, '1' high 30):
- Good frame 3C 00 19 05 5A after i_Start:
  - o_Dht_Drive_Low high exactly 40 cycles.
  - o_Done single pulse; outputs 3C/00/19/05/5A.
  - o_Err_Code=00; o_Busy low after o_Done.
- Checksum wrap frame FF FF 01 02 01: accepted, o_Done pulses, o_Temp_Int=01.
- Bad checksum 3C 00 19 05 5B following the good frame:
  - o_Err pulse, code 11, no o_Done.
  - Outputs still 3C/00/19/05/5A.
- No response (line held high): o_Err with code 01 exactly START_LOW_CYC+TIMEOUT_CYC+sync latency after start; line released.
- Line stuck high after bit 12: o_Err, code 10; second i_Start during the frame ignored (no restart, START_LOW seen once).
- i_Rst_n low for 1 cycle mid-bit-stream: all outputs 0, o_Dht_Drive_Low 0, no o_Err. A subsequent good frame reads correctly.
